// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
// Requester 0 carries ALU results and requester 1 carries load data.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int NUM_REQ  = 2;
    localparam int REQ_ALU  = 0;
    localparam int REQ_LD   = 1;

    // Round-robin pick. lastIdx is the requester granted most recently;
    // on a tie the other one wins.
    function automatic logic [NUM_REQ-1:0] rrPick(input logic [NUM_REQ-1:0] valid,
                                                  input logic               lastIdx);
        logic [NUM_REQ-1:0] pick;
        pick = '0;
        case (valid)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = lastIdx ? 2'b01 : 2'b10;
            default: pick = '0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter. It holds the index of the last granted
// requester, and that index moves only when a grant is actually accepted.
module rr_arbiter_2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic               Clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               fire,
    output logic [NUM_REQ-1:0] grant
);

    logic rrLast;

    // Reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            rrLast <= 1'b1;
        end else if (fire) begin
            rrLast <= grant[REQ_LD];
        end
    end

    always_comb begin
        grant = rrPick(valid, rrLast);
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load writeback.
// It also keeps the busy scoreboard that the issue stage uses for RAW/WAW stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
    input  logic                 Clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [ADDR_W-1:0]    req_reg0,
    input  logic [ADDR_W-1:0]    req_reg1,
    input  logic [DATA_W-1:0]    req_data0,
    input  logic [DATA_W-1:0]    req_data1,
    input  logic                 claim_valid,
    input  logic [ADDR_W-1:0]    claim_reg,
    output logic                 RegWrite,
    output logic [ADDR_W-1:0]    WriteReg,
    output logic [DATA_W-1:0]    WriteData,
    output logic [31:0]          busy,
    output logic                 claim_err
);
    import regfile_wb_arbiter_pkg::*;

    logic [1:0]        validGated;
    logic [1:0]        grant;
    logic              fire;
    logic [ADDR_W-1:0] winReg;
    logic [DATA_W-1:0] winData;
    logic [31:0]       setMask;
    logic [31:0]       clrMask;
    logic [31:0]       busyNext;
    logic              claimHit;

    // Masking valid during reset keeps req_ready low and blocks any transfer.
    assign validGated = req_valid & {2{rst}};

    rr_arbiter_2 uArb (
        .Clk   (Clk),
        .rst   (rst),
        .valid (validGated),
        .fire  (fire),
        .grant (grant)
    );

    assign fire      = |grant;
    assign req_ready = grant;

    always_comb begin
        winReg  = req_reg0;
        winData = req_data0;
        if (grant[REQ_LD]) begin
            winReg  = req_reg1;
            winData = req_data1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= fire;
            if (fire) begin
                WriteReg  <= winReg;
                WriteData <= winData;
            end
        end
    end

    // Set is applied after clear, so a claim wins over a same-cycle writeback.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (claim_valid) setMask[claim_reg] = 1'b1;
        if (fire)        clrMask[winReg]    = 1'b1;
        busyNext = (busy & ~clrMask) | setMask;
        claimHit = claim_valid && busy[claim_reg] && !(fire && (winReg == claim_reg));
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            busy      <= '0;
            claim_err <= 1'b0;
        end else begin
            busy      <= busyNext;
            claim_err <= claim_err | claimHit;
        end
    end

    grantOneHot: assert property (@(posedge Clk) !(grant[0] && grant[1]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench with a write scoreboard. Stimulus pushes the expected
// register-file writes, and a negedge monitor pops them and compares.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_t;

    logic        Clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [4:0]  req_reg0 = '0, req_reg1 = '0;
    logic [31:0] req_data0 = '0, req_data1 = '0;
    logic        claim_valid = 1'b0;
    logic [4:0]  claim_reg = '0;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] busy;
    logic        claim_err;

    int errors = 0;
    int checks = 0;
    wr_t expQ[$];

    regfile_wb_arbiter dut (
        .Clk(Clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_reg0(req_reg0), .req_reg1(req_reg1), .req_data0(req_data0), .req_data1(req_data1),
        .claim_valid(claim_valid), .claim_reg(claim_reg), .RegWrite(RegWrite),
        .WriteReg(WriteReg), .WriteData(WriteData), .busy(busy), .claim_err(claim_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive after the edge, then check the combinational ready and the state left by the previous edge.
    task automatic cyc(input logic r, input logic [1:0] v,
                       input logic [4:0] g0, input logic [31:0] d0,
                       input logic [4:0] g1, input logic [31:0] d1,
                       input logic cv, input logic [4:0] cr,
                       input logic [1:0] expReady, input logic [31:0] expBusy, input logic expErr);
        wr_t w;
        @(posedge Clk);
        #1;
        rst = r; req_valid = v; req_reg0 = g0; req_data0 = d0;
        req_reg1 = g1; req_data1 = d1; claim_valid = cv; claim_reg = cr;
        #2;
        chk("req_ready", {30'd0, req_ready}, {30'd0, expReady});
        chk("busy", busy, expBusy);
        chk("claim_err", {31'd0, claim_err}, {31'd0, expErr});
        if (expReady[0]) begin w.dest = g0; w.data = d0; expQ.push_back(w); end
        if (expReady[1]) begin w.dest = g1; w.data = d1; expQ.push_back(w); end
    endtask

    task automatic idle(input logic [31:0] expBusy, input logic expErr);
        cyc(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00, expBusy, expErr);
    endtask

    always @(negedge Clk) begin
        wr_t e;
        if (RegWrite === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %h expected no write", WriteReg, WriteData);
            end else begin
                e = expQ.pop_front();
                if (WriteReg !== e.dest || WriteData !== e.data) begin
                    errors++;
                    $display("FAIL write: got reg %0d data %h expected reg %0d data %h",
                             WriteReg, WriteData, e.dest, e.data);
                end
            end
        end
    end

    initial begin
        // Reset, then idle
        cyc(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00, 32'h0, 1'b0);
        cyc(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00, 32'h0, 1'b0);
        repeat (3) idle(32'h0, 1'b0);
        chk("reset_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("reset_WriteReg", {27'd0, WriteReg}, 32'd0);
        chk("reset_WriteData", WriteData, 32'd0);

        // Single requester 0
        cyc(1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 2'b01, 32'h0, 1'b0);
        idle(32'h0, 1'b0);
        chk("lat_RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("lat_WriteReg", {27'd0, WriteReg}, 32'd5);
        idle(32'h0, 1'b0);
        chk("drop_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("hold_WriteData", WriteData, 32'hDEADBEEF);

        // Requester 1 alone, so that requester 0 wins the next tie
        cyc(1'b1, 2'b10, 5'd0, 32'd0, 5'd3, 32'h1111, 1'b0, 5'd0, 2'b10, 32'h0, 1'b0);

        // Tie for four cycles: grants alternate 0,1,0,1 and the loser holds its request
        cyc(1'b1, 2'b11, 5'd1, 32'hA0, 5'd2, 32'hB0, 1'b0, 5'd0, 2'b01, 32'h0, 1'b0);
        cyc(1'b1, 2'b11, 5'd1, 32'hA1, 5'd2, 32'hB0, 1'b0, 5'd0, 2'b10, 32'h0, 1'b0);
        cyc(1'b1, 2'b11, 5'd1, 32'hA1, 5'd2, 32'hB1, 1'b0, 5'd0, 2'b01, 32'h0, 1'b0);
        cyc(1'b1, 2'b11, 5'd1, 32'hA2, 5'd2, 32'hB1, 1'b0, 5'd0, 2'b10, 32'h0, 1'b0);
        idle(32'h0, 1'b0);

        // Claim r7; requester 1 writes r7 two cycles later
        cyc(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 2'b00, 32'h0, 1'b0);
        idle(32'h80, 1'b0);
        cyc(1'b1, 2'b10, 5'd0, 32'd0, 5'd7, 32'h77, 1'b0, 5'd0, 2'b10, 32'h80, 1'b0);
        idle(32'h0, 1'b0);

        // Claim and clear of r9 in the same cycle: set wins and no error; a later claim sets the error
        cyc(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 2'b00, 32'h0, 1'b0);
        cyc(1'b1, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b1, 5'd9, 2'b01, 32'h200, 1'b0);
        cyc(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 2'b00, 32'h200, 1'b0);
        idle(32'h200, 1'b1);
        idle(32'h200, 1'b1);

        // A request raised while reset is low is never accepted and leaves no write behind
        cyc(1'b0, 2'b01, 5'd4, 32'h44, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00, 32'h200, 1'b1);
        idle(32'h0, 1'b0);
        chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_WriteReg", {27'd0, WriteReg}, 32'd0);
        idle(32'h0, 1'b0);
        idle(32'h0, 1'b0);

        chk("queue_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
